// File: rtl/mux_memoria_pkg.sv
// Shared constants for the registered N:1 channel mux with memory.
// Mode encodings, hold-counter width and the selector-width helper live here
// so the top and the arbiter agree on them.
package mux_memoria_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int HOLD_CNT_W = 8;

  // Selector/pointer width: clog2 of the channel count, never below one bit.
  function automatic int sel_width(input int channels);
    return ($clog2(channels) < 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational round-robin search: first valid channel at or above rr_ptr,
// wrapping from CHANNELS-1 back to 0. rr_ptr is always below CHANNELS.
module mux_rr_arbiter
  import mux_memoria_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid_in,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic                grant,
  output logic [SEL_W-1:0]    grant_idx
);

  // Walk the channels in priority order starting at rr_ptr; keep the first hit.
  always_comb begin
    int               pos;
    logic [SEL_W-1:0] idx;
    grant     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= CHANNELS) pos = pos - CHANNELS;
      idx = SEL_W'(pos);
      if (!grant && valid_in[idx]) begin
        grant     = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_memoria_nx1_param.sv
// Registered N:1 mux with output memory. Fixed mode picks the channel named by
// selector; round-robin mode rotates fairly over valid channels. On a no-grant
// edge data_out/sel_out hold and valid_output drops.
// Optional feature: define MUX_HOLD_CNT_EN to add the saturating hold_cnt
// output, counting consecutive no-grant edges.
module mux_memoria_nx1_param
  import mux_memoria_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      mode,
`ifdef MUX_HOLD_CNT_EN
  output logic [HOLD_CNT_W-1:0]     hold_cnt,
`endif
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_output,
  output logic [SEL_W-1:0]          sel_out
);

  // Channel tables padded to a power of two so any selector value indexes in
  // range; padding entries are never valid.
  localparam int NPAD = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  logic [NPAD-1:0]  valid_pad;
  logic [WIDTH-1:0] data_ch [NPAD];
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             sel_ok;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;

  mux_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .valid_in  (valid_in),
    .rr_ptr    (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Unpack the flat data bus and pad the valid vector.
  always_comb begin
    valid_pad                 = '0;
    valid_pad[CHANNELS-1:0]   = valid_in;
    for (int k = 0; k < NPAD; k++) data_ch[k] = '0;
    for (int k = 0; k < CHANNELS; k++) data_ch[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Grant decision for the current mode; out-of-range selectors never grant.
  always_comb begin
    sel_ok    = ({1'b0, selector} < CH_CNT);
    grant     = 1'b0;
    grant_idx = selector;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = sel_ok && valid_pad[selector];
      grant_idx = selector;
    end
  end

  // Output registers: load on grant, hold data/index otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out     <= '0;
      valid_output <= 1'b0;
      sel_out      <= '0;
    end else begin
      valid_output <= grant;
      if (grant) begin
        data_out <= data_ch[grant_idx];
        sel_out  <= grant_idx;
      end
    end
  end

  // Round-robin pointer moves past the granted channel; frozen in fixed mode
  // and on empty cycles.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr <= '0;
    end else if (mode == MODE_RR && rr_grant) begin
      rr_ptr <= (rr_idx == CH_LAST) ? '0 : rr_idx + SEL_W'(1);
    end
  end

`ifdef MUX_HOLD_CNT_EN
  // Count consecutive no-grant edges, saturating; any grant clears it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hold_cnt <= '0;
    end else if (grant) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_memoria_nx1_param.sv
// Directed bench for mux_memoria_nx1_param: a 4x4 instance for the main
// scenarios and a 3-channel instance for the non-power-of-two corner cases.
`timescale 1ns/1ps
module tb_mux_memoria_nx1_param;

  logic        clk;
  logic        reset_L;

  logic [15:0] data_in4;
  logic [3:0]  valid4;
  logic [1:0]  sel4;
  logic        mode4;
  logic [3:0]  dout4;
  logic        vout4;
  logic [1:0]  sout4;

  logic [11:0] data_in3;
  logic [2:0]  valid3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [3:0]  dout3;
  logic        vout3;
  logic [1:0]  sout3;

`ifdef MUX_HOLD_CNT_EN
  logic [7:0]  hcnt4;
  logic [7:0]  hcnt3;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mux_memoria_nx1_param #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in4),
    .valid_in     (valid4),
    .selector     (sel4),
    .mode         (mode4),
`ifdef MUX_HOLD_CNT_EN
    .hold_cnt     (hcnt4),
`endif
    .data_out     (dout4),
    .valid_output (vout4),
    .sel_out      (sout4)
  );

  mux_memoria_nx1_param #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in3),
    .valid_in     (valid3),
    .selector     (sel3),
    .mode         (mode3),
`ifdef MUX_HOLD_CNT_EN
    .hold_cnt     (hcnt3),
`endif
    .data_out     (dout3),
    .valid_output (vout3),
    .sel_out      (sout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one edge then check data_out / valid_output / sel_out of dut4.
  task automatic step4(input string tag, input int d, input int v, input int s);
    tick();
    check({tag, ".data"},  int'(dout4), d);
    check({tag, ".valid"}, int'(vout4), v);
    check({tag, ".sel"},   int'(sout4), s);
  endtask

  task automatic step3(input string tag, input int d, input int v, input int s);
    tick();
    check({tag, ".data"},  int'(dout3), d);
    check({tag, ".valid"}, int'(vout3), v);
    check({tag, ".sel"},   int'(sout3), s);
  endtask

  // Round-robin expected sequences for 4 channels, data = channel + 1.
  int rr_all_d [5] = '{1, 2, 3, 4, 1};
  int rr_all_s [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_L  = 1'b0;
    data_in4 = '0; valid4 = '0; sel4 = '0; mode4 = 1'b0;
    data_in3 = '0; valid3 = '0; sel3 = '0; mode3 = 1'b0;
    #3;
    check("rst.data",  int'(dout4), 0);
    check("rst.valid", int'(vout4), 0);
    check("rst.sel",   int'(sout4), 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    // Fixed mode, channel 2 = A
    data_in4 = 16'h0A00; valid4 = 4'b0100; sel4 = 2'd2; mode4 = 1'b0;
    step4("fix_ch2", 10, 1, 2);
`ifdef MUX_HOLD_CNT_EN
    check("fix_ch2.hold", int'(hcnt4), 0);
`endif

    // Memory: three empty edges
    valid4 = 4'b0000;
    for (int i = 0; i < 3; i++) step4($sformatf("mem%0d", i), 10, 0, 2);
`ifdef MUX_HOLD_CNT_EN
    check("mem.hold3", int'(hcnt4), 3);
`endif

    // Fixed mode: selected channel not valid, another is
    valid4 = 4'b0100; sel4 = 2'd1;
    step4("fix_inval", 10, 0, 2);

    // Round-robin, all valid, data 1..4
    data_in4 = 16'h4321; valid4 = 4'b1111; mode4 = 1'b1;
    for (int i = 0; i < 5; i++) step4($sformatf("rr_all%0d", i), rr_all_d[i], 1, rr_all_s[i]);
`ifdef MUX_HOLD_CNT_EN
    check("rr_all.hold", int'(hcnt4), 0);
`endif

    // Pointer now 1; grant ch1 alone to move it to 2, then wrap test
    valid4 = 4'b0010;
    step4("rr_p2", 2, 1, 1);
    valid4 = 4'b0011;
    step4("rr_wrap0", 1, 1, 0);
    step4("rr_wrap1", 2, 1, 1);
    step4("rr_wrap2", 1, 1, 0);

    // Empty cycle holds outputs and pointer (pointer = 1)
    valid4 = 4'b0000;
    step4("rr_empty", 1, 0, 0);
    valid4 = 4'b1111;
    step4("rr_after_empty", 2, 1, 1);

    // Single valid channel granted every edge (pointer 2 -> ch3 -> 0 -> ch3)
    valid4 = 4'b1000;
    step4("rr_single0", 4, 1, 3);
    step4("rr_single1", 4, 1, 3);

    // Mode switch: fixed grant leaves pointer at 0
    mode4 = 1'b0; sel4 = 2'd1; valid4 = 4'b1111;
    step4("sw_fixed", 2, 1, 1);
    mode4 = 1'b1;
    step4("sw_rr0", 1, 1, 0);
    step4("sw_rr1", 2, 1, 1);

    // Reset between edges while streaming (pointer is 2 here)
    reset_L = 1'b0;
    #2;
    check("mid_rst.data",  int'(dout4), 0);
    check("mid_rst.valid", int'(vout4), 0);
    check("mid_rst.sel",   int'(sout4), 0);
    @(negedge clk);
    reset_L = 1'b1;
    valid4 = 4'b0110;
    step4("post_rst", 2, 1, 1);

    // Three-channel instance
    data_in3 = 12'h321; valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd1;
    step3("c3_fix1", 2, 1, 1);
    sel3 = 2'd3;
    step3("c3_sel_oor", 2, 0, 1);
    mode3 = 1'b1;
    step3("c3_rr0", 1, 1, 0);
    step3("c3_rr1", 2, 1, 1);
    step3("c3_rr2", 3, 1, 2);
    step3("c3_rr3", 1, 1, 0);

`ifdef MUX_HOLD_CNT_EN
    valid4 = 4'b0000;
    for (int i = 0; i < 260; i++) tick();
    check("hold_sat", int'(hcnt4), 255);
    valid4 = 4'b0001;
    tick();
    check("hold_clear", int'(hcnt4), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_memoria_nx1_param.md
MUX_MEMORIA_NX1_PARAM -- requirements
Module: mux_memoria_nx1_param

Interface
REQ-001 Parameter WIDTH, default 4: data bits per channel; legal values 1..32.
REQ-002 Parameter CHANNELS, default 4: number of input channels; legal values 2..16; non-power-of-2 allowed.
REQ-003 Derived localparam SEL_W, equal to max(1, clog2(CHANNELS)): selector and pointer width.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-006 Port data_in, input, CHANNELS*WIDTH bits: flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port valid_in, input, CHANNELS bits: per-channel valid; bit k qualifies channel k.
REQ-008 Port selector, input, SEL_W bits: channel index, used in fixed mode only.
REQ-009 Port mode, input, 1 bit: 0 = fixed selector, 1 = round-robin.
REQ-010 Port data_out, output, WIDTH bits: registered selected data, with memory.
REQ-011 Port valid_output, output, 1 bit: data_out was loaded on the last edge.
REQ-012 Port sel_out, output, SEL_W bits: index of the channel that supplied data_out.

Function
REQ-013 All outputs shall be registered, with a latency of exactly 1 clk from sampled inputs to outputs.
REQ-014 In fixed mode, an edge with selector < CHANNELS and valid_in[selector]=1 shall load data_out from that channel, set sel_out to selector and set valid_output to 1.
REQ-015 In fixed mode, selector >= CHANNELS shall be treated as a no-grant.
REQ-016 On any no-grant edge, valid_output shall be 0 and data_out and sel_out shall hold their previous values (memory behaviour).
REQ-017 Round-robin mode shall keep an internal pointer rr_ptr (SEL_W bits).
REQ-018 In round-robin mode, the grant shall go to the first channel k with valid_in[k]=1, searching upward from rr_ptr and wrapping from CHANNELS-1 to 0.
REQ-019 On a round-robin grant of channel g, rr_ptr shall become g+1, or 0 when g = CHANNELS-1.
REQ-020 In round-robin mode, a cycle with no valid channel shall be a no-grant and shall leave rr_ptr unchanged.
REQ-021 In fixed mode, rr_ptr shall hold its value; a mode change shall take effect at the same edge it is sampled, with no flush and no extra latency.
REQ-022 Every channel continuously valid in round-robin mode shall be granted once within every CHANNELS consecutive cycles.
REQ-023 With a single valid channel, round-robin mode shall grant that channel on every edge.

Reset
REQ-024 Assertion of reset_L=0 shall immediately, without a clock edge, force data_out=0, valid_output=0, sel_out=0, rr_ptr=0 and (if compiled in) hold_cnt=0.
REQ-025 Reset asserted mid-stream shall discard any in-flight selection; the first edge after deassertion shall follow REQ-014..REQ-020 from the reset state.

Configuration
REQ-026 Macro MUX_HOLD_CNT_EN, when defined, shall add output port hold_cnt, 8 bits.
REQ-027 With MUX_HOLD_CNT_EN defined, hold_cnt shall increment on each no-grant edge, saturating at 255.
REQ-028 With MUX_HOLD_CNT_EN defined, hold_cnt shall clear to 0 on every grant edge.
REQ-029 Without MUX_HOLD_CNT_EN, the hold_cnt port and its logic shall be absent, and all other behaviour shall be unchanged.

Structure
REQ-030 Package mux_memoria_pkg shall hold MODE_FIXED=1'b0, MODE_RR=1'b1 and the hold_cnt width constant HOLD_CNT_W=8.
REQ-031 The round-robin search shall live in one sub-module, mux_rr_arbiter: inputs valid_in and rr_ptr; outputs grant (1 bit) and grant_idx (SEL_W bits).
REQ-032 The top level shall contain all registers and the data path.

Verification (WIDTH=4, CHANNELS=4 unless stated)
REQ-033 Reset then fixed mode, selector=2, data ch2=4'hA, valid_in=4'b0100 -> after one edge: data_out=A, valid_output=1, sel_out=2.
REQ-034 Memory: after REQ-033, valid_in=0 for 3 edges -> data_out stays A, valid_output=0 on each edge; hold_cnt=3 when MUX_HOLD_CNT_EN is defined.
REQ-035 Round-robin, all valid, ch0..3 data=1,2,3,4 -> data_out sequence 1,2,3,4,1; sel_out 0,1,2,3,0.
REQ-036 Round-robin, rr_ptr=2, valid_in=4'b0011 -> grant ch0 (wrap), then ch1, then ch0.
REQ-037 CHANNELS=3, fixed mode, selector=3 with valid_in=3'b111 -> no-grant; data_out and sel_out hold.
REQ-038 Reset asserted between edges during round-robin streaming -> outputs read 0 immediately; after release, the first grant goes to the lowest valid channel.
